// File: rtl/uart_tx.sv
// UART transmitter with 8N1 framing and a one-entry holding register.
// The holding register lets frames go out back-to-back with a single idle cycle between them.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       hold_reg;
    logic             hold_full;
    logic             accept;
    logic             bit_end;
    logic             in_frame;

    assign o_TX_Ready = ~hold_full;
    assign accept     = i_TX_DV & ~hold_full;
    assign bit_end    = (clk_cnt == CNT_MAX);
    assign in_frame   = (state == START) || (state == DATA) || (state == STOP);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_TX_Done <= 1'b0;

            // A byte offered while a frame is on the line waits in the holding register.
            if (accept && in_frame) begin
                hold_reg  <= i_TX_Byte;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (accept) begin
                        shift_reg   <= i_TX_Byte;
                        state       <= START;
                        o_TX_Serial <= 1'b0;
                        o_TX_Active <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        state       <= DATA;
                        o_TX_Serial <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state       <= STOP;
                            o_TX_Serial <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_TX_Serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        state       <= CLEANUP;
                        o_TX_Active <= 1'b0;
                        o_TX_Done   <= 1'b1;
                        o_TX_Serial <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end

                CLEANUP: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    // A queued byte wins over a fresh strobe; Ready is low then, so none can arrive.
                    if (hold_full) begin
                        shift_reg   <= hold_reg;
                        hold_reg    <= '0;
                        hold_full   <= 1'b0;
                        state       <= START;
                        o_TX_Serial <= 1'b0;
                        o_TX_Active <= 1'b1;
                    end else if (accept) begin
                        shift_reg   <= i_TX_Byte;
                        state       <= START;
                        o_TX_Serial <= 1'b0;
                        o_TX_Active <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        o_TX_Serial <= 1'b1;
                        o_TX_Active <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: cycle-exact frame vectors plus a line decoder feeding a byte scoreboard.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       dv;
    logic [7:0] tx_byte;
    logic       ready;
    logic       active;
    logic       serial;
    logic       done;

    int checks = 0;
    int errors = 0;
    int mon_frames = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_n),
        .i_TX_DV    (dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Ready (ready),
        .o_TX_Active(active),
        .o_TX_Serial(serial),
        .o_TX_Done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [7:0] b);
        dv      = v;
        tx_byte = b;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Line decoder: finds the start edge, samples each bit at its centre, pops the scoreboard.
    initial begin
        logic       mon_busy;
        int         mon_cnt;
        int         idx;
        logic [7:0] mon_data;
        mon_busy = 1'b0;
        mon_cnt  = 0;
        mon_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (serial == 1'b0) begin
                    mon_busy = 1'b1;
                    mon_cnt  = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == CPB / 2) begin
                    checkOutput("mon_start_bit", serial, 1'b0);
                end else if (mon_cnt > CPB && mon_cnt < 9 * CPB && ((mon_cnt - CPB / 2) % CPB) == 0) begin
                    idx = (mon_cnt - CPB / 2) / CPB - 1;
                    mon_data[idx] = serial;
                end else if (mon_cnt == 9 * CPB + CPB / 2) begin
                    checkOutput("mon_stop_bit", serial, 1'b1);
                    mon_busy = 1'b0;
                    mon_frames++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL mon_unexpected_frame: got %02h, expected no frame", mon_data);
                    end else begin
                        checkByte("mon_byte", mon_data, sb_q.pop_front());
                    end
                end
            end
        end
    end

    // Drives one byte from idle and checks every cycle of its frame plus the Done cycle.
    task automatic checkFrame(input logic [7:0] data, input logic [9:0] frame);
        logic exp_serial;
        @(negedge clk);
        checkOutput("ready_before_dv", ready, 1'b1);
        applyStimulus(1'b1, data);
        sb_q.push_back(data);
        for (int k = 1; k <= 10 * CPB + 1; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, 8'h00);
            exp_serial = (k <= 10 * CPB) ? frame[(k - 1) / CPB] : 1'b1;
            checkOutput("frame_serial", serial, exp_serial);
            checkOutput("frame_active", active, k <= 10 * CPB);
            checkOutput("frame_done", done, k == 10 * CPB + 1);
            checkOutput("frame_ready", ready, 1'b1);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        int frames_start;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, {1'b1, 8'h00, 1'b0}};
        vecs[2] = '{8'hFF, {1'b1, 8'hFF, 1'b0}};
        vecs[3] = '{8'h81, {1'b1, 8'h81, 1'b0}};
        vecs[4] = '{8'h3C, {1'b1, 8'h3C, 1'b0}};

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00);

        $display("[TB] reset state");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_serial", serial, 1'b1);
            checkOutput("rst_ready", ready, 1'b1);
            checkOutput("rst_active", active, 1'b0);
            checkOutput("rst_done", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_serial", serial, 1'b1);
            checkOutput("post_rst_ready", ready, 1'b1);
            checkOutput("post_rst_active", active, 1'b0);
            checkOutput("post_rst_done", done, 1'b0);
        end

        $display("[TB] single frames");
        foreach (vecs[i]) begin
            checkFrame(vecs[i].data, vecs[i].frame);
            idleCycles(2);
        end

        $display("[TB] back-to-back");
        done_cnt = 0;
        @(negedge clk);
        applyStimulus(1'b1, 8'h55);
        sb_q.push_back(8'h55);
        for (int k = 1; k <= 20 * CPB + 4; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k == 1) applyStimulus(1'b0, 8'h00);
            if (k == 10) begin
                checkOutput("b2b_ready_pre", ready, 1'b1);
                applyStimulus(1'b1, 8'h0F);
                sb_q.push_back(8'h0F);
            end
            if (k == 11) begin
                applyStimulus(1'b0, 8'h00);
                checkOutput("b2b_ready_low", ready, 1'b0);
            end
            if (k == 10 * CPB + 1) begin
                checkOutput("b2b_gap_serial", serial, 1'b1);
                checkOutput("b2b_gap_done", done, 1'b1);
                checkOutput("b2b_gap_ready", ready, 1'b0);
                checkOutput("b2b_gap_active", active, 1'b0);
            end
            if (k == 10 * CPB + 2) begin
                checkOutput("b2b_start2_serial", serial, 1'b0);
                checkOutput("b2b_start2_active", active, 1'b1);
                checkOutput("b2b_ready_back", ready, 1'b1);
            end
        end
        checkCount("b2b_done_pulses", done_cnt, 2);
        idleCycles(2);

        $display("[TB] overrun");
        frames_start = mon_frames;
        done_cnt = 0;
        @(negedge clk);
        applyStimulus(1'b1, 8'h11);
        sb_q.push_back(8'h11);
        for (int k = 1; k <= 20 * CPB + 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k == 1) applyStimulus(1'b0, 8'h00);
            if (k == 5) begin
                checkOutput("ovr_ready_pre", ready, 1'b1);
                applyStimulus(1'b1, 8'h22);
                sb_q.push_back(8'h22);
            end
            if (k == 6) begin
                checkOutput("ovr_ready_full", ready, 1'b0);
                applyStimulus(1'b1, 8'h33);
            end
            if (k == 7) begin
                applyStimulus(1'b0, 8'h00);
                checkOutput("ovr_ready_still_full", ready, 1'b0);
            end
        end
        checkCount("ovr_done_pulses", done_cnt, 2);
        checkCount("ovr_frames", mon_frames - frames_start, 2);
        checkCount("ovr_sb_drained", sb_q.size(), 0);
        idleCycles(2);

        $display("[TB] dv in cleanup");
        @(negedge clk);
        applyStimulus(1'b1, 8'h96);
        sb_q.push_back(8'h96);
        for (int k = 1; k <= 20 * CPB + 3; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, 8'h00);
            if (k == 10 * CPB + 1) begin
                checkOutput("cln_done", done, 1'b1);
                checkOutput("cln_ready", ready, 1'b1);
                applyStimulus(1'b1, 8'hC3);
                sb_q.push_back(8'hC3);
            end
            if (k == 10 * CPB + 2) begin
                applyStimulus(1'b0, 8'h00);
                checkOutput("cln_next_serial", serial, 1'b0);
                checkOutput("cln_next_active", active, 1'b1);
                checkOutput("cln_next_done", done, 1'b0);
            end
            if (k == 10 * CPB + 6) checkOutput("cln_c3_bit0", serial, 1'b1);
            if (k == 20 * CPB + 2) checkOutput("cln_done2", done, 1'b1);
        end
        checkCount("cln_sb_drained", sb_q.size(), 0);
        idleCycles(2);

        $display("[TB] mid-frame reset");
        @(negedge clk);
        applyStimulus(1'b1, 8'hF0);
        for (int k = 1; k <= 4 * CPB + 2; k++) begin
            @(negedge clk);
            if (k == 1) applyStimulus(1'b0, 8'h00);
            if (k == 5) applyStimulus(1'b1, 8'h99);
            if (k == 6) applyStimulus(1'b0, 8'h00);
        end
        checkOutput("mid_bit3_low", serial, 1'b0);
        checkOutput("mid_hold_full", ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_async_serial", serial, 1'b1);
        checkOutput("mid_async_active", active, 1'b0);
        checkOutput("mid_async_ready", ready, 1'b1);
        idleCycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_post_serial", serial, 1'b1);
        checkOutput("mid_post_done", done, 1'b0);
        checkFrame(8'h7E, {1'b1, 8'h7E, 1'b0});
        idleCycles(4 * CPB);

        checkCount("final_sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
